// File: rtl/sram_burst_master.sv
// Burst initiator for a single-port SRAM wrapper. It turns burst commands and valid/ready data streams
// into per-cycle wen/ren strobes and returns read data through a credit-protected fall-through buffer.
module sram_burst_master #(
  parameter int DATA_BIT = 256,
  parameter int DEPTH    = 128,
  parameter int ADDR_BIT = $clog2(DEPTH),
  parameter int RD_LAT   = 2,
  parameter int OBUF     = RD_LAT + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_BIT-1:0] cmd_addr,
  input  logic [ADDR_BIT:0]   cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_BIT-1:0] wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_BIT-1:0] rd_data,
  output logic [ADDR_BIT-1:0] sram_addr,
  output logic                sram_wen,
  output logic                sram_ren,
  output logic [DATA_BIT-1:0] sram_wdata,
  input  logic [DATA_BIT-1:0] sram_rdata,
  output logic                busy,
  output logic                done
);

  localparam int CNT_BIT = $clog2(OBUF + 1);
  localparam int PTR_BIT = (OBUF > 1) ? $clog2(OBUF) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_BIT-1:0]   cur, cur_inc;
  logic [ADDR_BIT:0]     remaining;
  logic                  done_nxt;
  logic [RD_LAT-1:0]     vpipe;
  logic [DATA_BIT-1:0]   buf_mem [OBUF];
  logic [PTR_BIT-1:0]    wptr, rptr;
  logic [CNT_BIT-1:0]    count, inflight;
  logic [CNT_BIT:0]      occupied;
  logic                  cmd_fire, wr_fire, issue, credit;
  logic                  rd_tag, empty, push, pop;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign wr_ready   = (state == WRITE);
  assign cmd_fire   = cmd_valid & cmd_ready;
  assign wr_fire    = wr_valid & wr_ready;
  assign sram_wen   = wr_fire;
  assign sram_wdata = wr_data;
  assign sram_addr  = cur;
  assign cur_inc    = (cur == ADDR_BIT'(DEPTH - 1)) ? '0 : cur + 1'b1;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + CNT_BIT'(vpipe[i]);
  end

  // Every issued read owns a buffer slot until it is popped, so a stalled consumer never loses a word.
  assign occupied = (CNT_BIT+1)'(inflight) + (CNT_BIT+1)'(count);
  assign credit   = occupied < (CNT_BIT+1)'(OBUF);
  assign issue    = (state == READ) && (remaining != '0) && credit;
  assign sram_ren = issue;

  // Fall-through buffer: a returning word goes straight out when the buffer is empty.
  assign rd_tag   = vpipe[RD_LAT-1];
  assign empty    = (count == '0);
  assign rd_valid = !empty || rd_tag;
  assign rd_data  = empty ? sram_rdata : buf_mem[rptr];
  assign pop      = rd_ready && !empty;
  assign push     = rd_tag && !(empty && rd_ready);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: if (cmd_fire) begin
        if (cmd_len == '0) done_nxt = 1'b1;
        else               state_nxt = cmd_wr ? WRITE : READ;
      end
      WRITE: if (wr_fire && remaining == (ADDR_BIT+1)'(1)) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      READ: if (issue && remaining == (ADDR_BIT+1)'(1)) state_nxt = DRAIN;
      DRAIN: if (inflight == '0 && empty) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      cur       <= '0;
      remaining <= '0;
      vpipe     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      for (int unsigned i = 0; i < OBUF; i++) buf_mem[i] <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (cmd_fire) begin
        cur       <= cmd_addr;
        remaining <= cmd_len;
      end else if (wr_fire || issue) begin
        cur       <= cur_inc;
        remaining <= remaining - 1'b1;
      end
      vpipe[0] <= issue;
      for (int unsigned i = 1; i < RD_LAT; i++) vpipe[i] <= vpipe[i-1];
      if (push) begin
        buf_mem[wptr] <= sram_rdata;
        wptr <= (wptr == PTR_BIT'(OBUF - 1)) ? '0 : wptr + 1'b1;
      end
      if (pop) rptr <= (rptr == PTR_BIT'(OBUF - 1)) ? '0 : rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_burst_master.sv
// Bench for sram_burst_master: a behavioural SRAM wrapper with RD_LAT read latency plus an
// address-indexed scoreboard of written words; bursts use randomized data and handshakes.
module tb_sram_burst_master;

  localparam int DATA_BIT = 32;
  localparam int DEPTH    = 20;
  localparam int ADDR_BIT = 5;
  localparam int RD_LAT   = 2;
  localparam int OBUF     = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR_BIT-1:0] cmd_addr;
  logic [ADDR_BIT:0]   cmd_len;
  logic                wr_valid, wr_ready;
  logic [DATA_BIT-1:0] wr_data;
  logic                rd_valid, rd_ready;
  logic [DATA_BIT-1:0] rd_data;
  logic [ADDR_BIT-1:0] sram_addr;
  logic                sram_wen, sram_ren;
  logic [DATA_BIT-1:0] sram_wdata, sram_rdata;
  logic                busy, done;

  int checks   = 0;
  int failures = 0;

  logic [DATA_BIT-1:0] ref_mem  [DEPTH];
  logic [DATA_BIT-1:0] sram_mem [DEPTH];
  logic [DATA_BIT-1:0] rd_pipe  [RD_LAT];

  sram_burst_master #(
    .DATA_BIT(DATA_BIT), .DEPTH(DEPTH), .ADDR_BIT(ADDR_BIT), .RD_LAT(RD_LAT), .OBUF(OBUF)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .sram_addr(sram_addr), .sram_wen(sram_wen), .sram_ren(sram_ren),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // SRAM wrapper: a read sampled at one edge is visible RD_LAT cycles later.
  always @(posedge clk) begin
    if (sram_wen) sram_mem[sram_addr] <= sram_wdata;
    if (sram_ren) rd_pipe[0] <= sram_mem[sram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rdata = rd_pipe[RD_LAT-1];

  task automatic issue_cmd(input logic wr, input int addr, input int len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = ADDR_BIT'(addr);
    cmd_len   = (ADDR_BIT+1)'(len);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready: got %b expected 1", cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, wr_ready, rd_valid, sram_wen, sram_ren, busy, done} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 1000000",
               {cmd_ready, wr_ready, rd_valid, sram_wen, sram_ren, busy, done});
    end
    checks++;
    if (sram_addr !== '0) begin
      failures++;
      $display("FAIL reset_addr: got %0d expected 0", sram_addr);
    end
    rst = 1'b0;
  endtask

  task automatic do_write(input int addr, input int len, input int vprob, input bit consec);
    int k = 0;
    int cycles = 0;
    int dones = 0;
    logic [ADDR_BIT-1:0] exp_a;
    issue_cmd(1'b1, addr, len);
    while (k < len && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      wr_valid = ($urandom_range(99) < vprob);
      wr_data  = $urandom;
      #1;
      if (done) dones++;
      checks++;
      if (sram_ren !== 1'b0) begin
        failures++;
        $display("FAIL write_ren_overlap: got %b expected 0", sram_ren);
      end
      if (wr_valid && wr_ready) begin
        exp_a = ADDR_BIT'((addr + k) % DEPTH);
        checks++;
        if (sram_wen !== 1'b1 || sram_addr !== exp_a || sram_wdata !== wr_data) begin
          failures++;
          $display("FAIL write_beat: got wen=%b addr=%0d data=%h expected wen=1 addr=%0d data=%h",
                   sram_wen, sram_addr, sram_wdata, exp_a, wr_data);
        end
        ref_mem[exp_a] = wr_data;
        k++;
      end else begin
        checks++;
        if (sram_wen !== 1'b0) begin
          failures++;
          $display("FAIL write_idle_wen: got %b expected 0", sram_wen);
        end
      end
    end
    checks++;
    if (k != len || dones != 0) begin
      failures++;
      $display("FAIL write_progress: got beats=%0d early_done=%0d expected beats=%0d early_done=0", k, dones, len);
    end
    if (consec) begin
      checks++;
      if (cycles != len) begin
        failures++;
        $display("FAIL write_consecutive: got %0d cycles expected %0d", cycles, len);
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sram_wen !== 1'b0) begin
      failures++;
      $display("FAIL write_done: got done=%b busy=%b wen=%b expected 1 0 0", done, busy, sram_wen);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL write_done_pulse: got %b expected 0", done);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: ready held low for the first 10 cycles
  task automatic do_read(input int addr, input int len, input int mode);
    int issued = 0;
    int got = 0;
    int cycles = 0;
    int dones = 0;
    int first_ren = -1;
    int first_rv = -1;
    int last_rv = -1;
    logic hold_v = 1'b0;
    logic [DATA_BIT-1:0] hold_d = '0;
    logic [ADDR_BIT-1:0] exp_a;
    issue_cmd(1'b0, addr, len);
    while (dones == 0 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'($urandom_range(1));
        default: rd_ready = (cycles > 10);
      endcase
      #1;
      checks++;
      if (sram_wen !== 1'b0) begin
        failures++;
        $display("FAIL read_wen_overlap: got %b expected 0", sram_wen);
      end
      if (sram_ren) begin
        exp_a = ADDR_BIT'((addr + issued) % DEPTH);
        checks++;
        if (sram_addr !== exp_a) begin
          failures++;
          $display("FAIL read_addr: got %0d expected %0d", sram_addr, exp_a);
        end
        if (first_ren < 0) first_ren = cycles;
        issued++;
      end
      checks++;
      if (issued - got > OBUF || issued > len) begin
        failures++;
        $display("FAIL read_credit: got outstanding=%0d issued=%0d expected <=%0d and <=%0d",
                 issued - got, issued, OBUF, len);
      end
      if (mode == 2 && cycles == 10) begin
        checks++;
        if (issued != OBUF) begin
          failures++;
          $display("FAIL read_stall_credit: got %0d issued expected %0d", issued, OBUF);
        end
      end
      if (hold_v) begin
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== hold_d) begin
          failures++;
          $display("FAIL read_hold: got valid=%b data=%h expected valid=1 data=%h", rd_valid, rd_data, hold_d);
        end
      end
      hold_v = 1'b0;
      if (rd_valid === 1'b1) begin
        if (first_rv < 0) first_rv = cycles;
        last_rv = cycles;
        if (rd_ready) begin
          exp_a = ADDR_BIT'((addr + got) % DEPTH);
          checks++;
          if (rd_data !== ref_mem[exp_a]) begin
            failures++;
            $display("FAIL read_data: got %h expected %h (word %0d)", rd_data, ref_mem[exp_a], got);
          end
          got++;
        end else begin
          hold_v = 1'b1;
          hold_d = rd_data;
        end
      end
      if (done === 1'b1) begin
        dones++;
        checks++;
        if (got != len || busy !== 1'b0) begin
          failures++;
          $display("FAIL read_done: got words=%0d busy=%b expected words=%0d busy=0", got, busy, len);
        end
      end
    end
    rd_ready = 1'b0;
    checks++;
    if (dones != 1) begin
      failures++;
      $display("FAIL read_timeout: got done count %0d expected 1", dones);
    end
    if (mode == 0) begin
      checks++;
      if (first_rv - first_ren != RD_LAT || last_rv - first_rv != len - 1) begin
        failures++;
        $display("FAIL read_latency: got lat=%0d span=%0d expected lat=%0d span=%0d",
                 first_rv - first_ren, last_rv - first_rv, RD_LAT, len - 1);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL read_done_pulse: got %b expected 0", done);
    end
  endtask

  task automatic test_len_zero();
    issue_cmd(1'b1, 3, 0);
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL len0_done: got done=%b busy=%b expected 1 0", done, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL len0_after: got done=%b cmd_ready=%b expected 0 1", done, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_read();
    int issued = 0;
    int cycles = 0;
    int bad = 0;
    rd_ready = 1'b0;
    issue_cmd(1'b0, 2, 8);
    while (issued < 2 && cycles < 50) begin
      @(negedge clk);
      cycles++;
      #1;
      if (sram_ren) issued++;
    end
    checks++;
    if (issued != 2) begin
      failures++;
      $display("FAIL rst_mid_issue: got %0d reads expected 2", issued);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, busy, rd_valid, done} !== 4'b1000) begin
      failures++;
      $display("FAIL rst_mid_state: got %b expected 1000", {cmd_ready, busy, rd_valid, done});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0 || rd_valid !== 1'b0 || sram_ren !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", bad);
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
    test_reset();
    do_write(5, 4, 100, 1'b1);
    do_read(5, 4, 0);
    do_write(DEPTH - 2, 3, 100, 1'b1);
    do_read(DEPTH - 2, 3, 0);
    do_write(int'($urandom_range(DEPTH - 1)), DEPTH, 50, 1'b0);
    do_read(1, 16, 2);
    do_read(int'($urandom_range(DEPTH - 1)), DEPTH, 1);
    test_len_zero();
    test_reset_mid_read();
    do_read(7, 6, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
